// File: rtl/cpu_fetch_pkg.sv
// Shared definitions for the instruction-fetch front end.
//   - Exception cause codes reported in-band with fetch faults. The values
//     match the core's existing RV32 mcause encodings.
//   - fetch_entry_t: one prefetch-queue slot {fault, cause, pc, data}, 69 bits.
//   - make_fault(): builds a fault slot that carries no instruction word.
package cpu_fetch_pkg;

  localparam logic [3:0] EXC_CAUSE_INSTRUCTION_ADDR_MISALIGNED = 4'd0;
  localparam logic [3:0] EXC_CAUSE_INSTRUCTION_ACCESS_FAULT    = 4'd1;

  typedef struct packed {
    logic        fault;
    logic [3:0]  cause;
    logic [31:0] pc;
    logic [31:0] data;
  } fetch_entry_t;

  localparam int unsigned FETCH_ENTRY_W = $bits(fetch_entry_t);

  function automatic fetch_entry_t make_fault(input logic [31:0] pc,
                                              input logic [3:0]  cause);
    fetch_entry_t e;
    e.fault = 1'b1;
    e.cause = cause;
    e.pc    = pc;
    e.data  = '0;
    return e;
  endfunction

endpackage

// File: rtl/cpu_fetch_queue.sv
// First-word-fall-through prefetch FIFO for cpu_fetch_unit.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   push_i          write push_entry_i at the tail (ignored when full)
//   push_entry_i    entry to store
//   pop_i           drop the head entry (ignored when empty)
//   flush_i         empty the queue; overrides push and pop in the same cycle
//   head_o          head entry (meaningful only while valid_o)
//   valid_o         queue not empty
//   level_o         number of occupied entries, 0..DEPTH
// DEPTH must be a power of two so the pointers wrap by plain overflow.
module cpu_fetch_queue
  import cpu_fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_i,
  input  fetch_entry_t               push_entry_i,
  input  logic                       pop_i,
  input  logic                       flush_i,
  output fetch_entry_t               head_o,
  output logic                       valid_o,
  output logic [$clog2(DEPTH+1)-1:0] level_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned LVL_W = $clog2(DEPTH + 1);
  localparam logic [LVL_W-1:0] FULL_LEVEL = LVL_W'(DEPTH);

  fetch_entry_t     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [LVL_W-1:0] level_q;
  logic             do_push;
  logic             do_pop;

  assign do_push = push_i && (level_q != FULL_LEVEL) && !flush_i;
  assign do_pop  = pop_i  && (level_q != '0)         && !flush_i;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of block order.
  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

  // NOTE: the storage array is deliberately not reset; occupancy is tracked
  // by level_q and stale slots are never presented as valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_entry_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign valid_o = (level_q != '0);
  assign level_o = level_q;

endmodule

// File: rtl/cpu_fetch_unit.sv
// Prefetching instruction-fetch front end for the RV32 core.
// Fetches sequential words ahead of execution over a single-outstanding
// memory handshake into a FWFT queue, hands them to decode via valid/ready
// and reports fetch faults in-band. Restarts at a new PC on redirect.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   ma_addr/ma_rd_req   fetch address and registered read request
//   ma_data_mask        always all four byte lanes
//   ma_data_in/ma_done  read data and completion
//   ma_timeout          request failed (access fault), wins over ma_done
//   redirect/redirect_pc  one-cycle flush and restart
//   inst_valid/inst_ready/inst_data/inst_pc/inst_fault/inst_fault_cause
//                       head of the prefetch queue towards decode
//   queue_level         occupied queue entries
module cpu_fetch_unit
  import cpu_fetch_pkg::*;
#(
  parameter logic [31:0] EXEC_START_ADDR = 32'h4000_0000,
  parameter int unsigned QUEUE_DEPTH     = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  output logic [31:0]                      ma_addr,
  output logic                             ma_rd_req,
  output logic [3:0]                       ma_data_mask,
  input  logic [31:0]                      ma_data_in,
  input  logic                             ma_done,
  input  logic                             ma_timeout,
  input  logic                             redirect,
  input  logic [31:0]                      redirect_pc,
  output logic                             inst_valid,
  input  logic                             inst_ready,
  output logic [31:0]                      inst_data,
  output logic [31:0]                      inst_pc,
  output logic                             inst_fault,
  output logic [3:0]                       inst_fault_cause,
  output logic [$clog2(QUEUE_DEPTH+1)-1:0] queue_level
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_REQ   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;  // waiting out a request made stale by redirect
  localparam logic [1:0] ST_HALT  = 2'd3;  // fault queued, wait for redirect

  localparam int unsigned LVL_W = $clog2(QUEUE_DEPTH + 1);
  localparam logic [LVL_W:0] DEPTH_W = (LVL_W + 1)'(QUEUE_DEPTH);

  logic [1:0]       state_q, state_d;
  logic [31:0]      fetch_pc_q, fetch_pc_d;
  logic [31:0]      req_addr_q, req_addr_d;
  logic             rd_req_q, rd_req_d;

  logic             push;
  fetch_entry_t     push_entry;
  logic             pop;
  fetch_entry_t     head;
  logic             head_valid;
  logic [LVL_W-1:0] level;

  logic             pending;
  logic [LVL_W:0]   occupancy;
  logic             room;
  logic             resp;

  // A request in flight holds a credit, so its response always finds a slot.
  assign pending   = (state_q == ST_REQ);
  assign occupancy = {1'b0, level} + {{LVL_W{1'b0}}, pending};
  assign room      = (occupancy < DEPTH_W);
  assign resp      = ma_done || ma_timeout;

  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_addr_d = req_addr_q;
    rd_req_d   = rd_req_q;
    push       = 1'b0;
    push_entry = '0;

    if (redirect) begin
      fetch_pc_d = redirect_pc;
      if (rd_req_q) begin
        // An issued request cannot be aborted: keep it on the bus and discard
        // its response later, unless it completes in this very cycle.
        if (resp) begin
          rd_req_d = 1'b0;
          state_d  = ST_IDLE;
        end else begin
          state_d  = ST_DRAIN;
        end
      end else begin
        state_d = ST_IDLE;
      end
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (fetch_pc_q[1:0] != 2'b00) begin
            if (room) begin
              push       = 1'b1;
              push_entry = make_fault(fetch_pc_q, EXC_CAUSE_INSTRUCTION_ADDR_MISALIGNED);
              state_d    = ST_HALT;
            end
          end else if (room) begin
            rd_req_d   = 1'b1;
            req_addr_d = fetch_pc_q;
            state_d    = ST_REQ;
          end
        end
        ST_REQ: begin
          if (ma_timeout) begin
            rd_req_d   = 1'b0;
            push       = 1'b1;
            push_entry = make_fault(req_addr_q, EXC_CAUSE_INSTRUCTION_ACCESS_FAULT);
            state_d    = ST_HALT;
          end else if (ma_done) begin
            rd_req_d         = 1'b0;
            push             = 1'b1;
            push_entry.fault = 1'b0;
            push_entry.cause = '0;
            push_entry.pc    = req_addr_q;
            push_entry.data  = ma_data_in;
            fetch_pc_d       = fetch_pc_q + 32'd4;
            state_d          = ST_IDLE;
          end
        end
        ST_DRAIN: begin
          if (resp) begin
            rd_req_d = 1'b0;
            state_d  = ST_IDLE;
          end
        end
        ST_HALT: begin
          state_d = ST_HALT;
        end
        default: begin
          rd_req_d = 1'b0;
          state_d  = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      fetch_pc_q <= EXEC_START_ADDR;
      req_addr_q <= EXEC_START_ADDR;
      rd_req_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_addr_q <= req_addr_d;
      rd_req_q   <= rd_req_d;
    end
  end

  // Redirect flushes the queue and overrides any pop or push in that cycle.
  assign pop = head_valid && inst_ready && !redirect;

  cpu_fetch_queue #(
    .DEPTH (QUEUE_DEPTH)
  ) u_queue (
    .clk          (clk),
    .rst          (rst),
    .push_i       (push),
    .push_entry_i (push_entry),
    .pop_i        (pop),
    .flush_i      (redirect),
    .head_o       (head),
    .valid_o      (head_valid),
    .level_o      (level)
  );

  // While a request is outstanding (REQ or DRAIN) the bus address is the one
  // captured at issue; fetch_pc may already point at a redirect target.
  assign ma_addr      = rd_req_q ? req_addr_q : fetch_pc_q;
  assign ma_rd_req    = rd_req_q;
  assign ma_data_mask = 4'b1111;

  // Head fields are masked while empty so stale slots never leak out.
  assign inst_valid       = head_valid;
  assign inst_data        = head_valid ? head.data  : '0;
  assign inst_pc          = head_valid ? head.pc    : '0;
  assign inst_fault       = head_valid && head.fault;
  assign inst_fault_cause = head_valid ? head.cause : '0;
  assign queue_level      = level;

endmodule

// File: tb/tb_cpu_fetch_unit.sv
module tb_cpu_fetch_unit;

  localparam int          DEPTH = 4;
  localparam logic [31:0] START = 32'h4000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] ma_addr;
  logic        ma_rd_req;
  logic [3:0]  ma_data_mask;
  logic [31:0] ma_data_in;
  logic        ma_done;
  logic        ma_timeout;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic        inst_fault;
  logic [3:0]  inst_fault_cause;
  logic [2:0]  queue_level;

  always #5 clk = ~clk;

  cpu_fetch_unit #(
    .EXEC_START_ADDR (START),
    .QUEUE_DEPTH     (DEPTH)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .ma_addr          (ma_addr),
    .ma_rd_req        (ma_rd_req),
    .ma_data_mask     (ma_data_mask),
    .ma_data_in       (ma_data_in),
    .ma_done          (ma_done),
    .ma_timeout       (ma_timeout),
    .redirect         (redirect),
    .redirect_pc      (redirect_pc),
    .inst_valid       (inst_valid),
    .inst_ready       (inst_ready),
    .inst_data        (inst_data),
    .inst_pc          (inst_pc),
    .inst_fault       (inst_fault),
    .inst_fault_cause (inst_fault_cause),
    .queue_level      (queue_level)
  );

  typedef struct {
    bit        fault;
    bit [3:0]  cause;
    bit [31:0] pc;
    bit [31:0] data;
  } ent_t;

  // ---------------- reference model state ----------------
  ent_t      mq[$];        // expected queue contents, head at index 0
  bit [31:0] m_pc;         // next sequential fetch address
  bit [31:0] m_req_addr;   // address of the outstanding request
  bit        m_busy;       // a request is on the bus
  bit        m_discard;    // its response must be dropped
  bit        m_halted;     // fault queued, waiting for redirect
  bit        m_live = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc_n = 0;

  ent_t      acc_log[$];   // entries consumed by decode
  int        acc_cyc[$];
  bit [31:0] req_log[$];   // addresses of newly started requests
  bit        prev_rd = 1'b0;

  // memory responder configuration
  int        lat_cfg  = 0;   // <0 : random 0..3
  bit        to_en    = 1'b0;
  bit [31:0] to_addr  = '0;
  bit        rand_to  = 1'b0;
  int        resp_cnt = -1;

  function automatic bit [31:0] mem_word(input bit [31:0] a);
    return {a[7:0], a[31:8]} ^ 32'hC3C3_5A5A;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc_n);
    end
  endtask

  // Model: one architectural step per clock edge.
  always @(posedge clk) begin : model
    bit   resp;
    int   lvl0;
    ent_t e;
    cyc_n++;
    if (rst) begin
      mq.delete();
      m_pc = START; m_req_addr = START;
      m_busy = 0; m_discard = 0; m_halted = 0; m_live = 1;
    end else if (m_live) begin
      resp = ma_done || ma_timeout;
      lvl0 = mq.size();
      if (redirect) begin
        mq.delete();
        m_pc     = redirect_pc;
        m_halted = 0;
        if (m_busy && !resp) m_discard = 1;
        else begin m_busy = 0; m_discard = 0; end
      end else begin
        if (lvl0 > 0 && inst_ready) void'(mq.pop_front());
        if (m_busy) begin
          if (resp) begin
            m_busy = 0;
            if (!m_discard) begin
              e.pc = m_req_addr;
              if (ma_timeout) begin
                e.fault = 1; e.cause = 4'd1; e.data = 0;
                m_halted = 1;
              end else begin
                e.fault = 0; e.cause = 4'd0; e.data = ma_data_in;
                m_pc = m_pc + 32'd4;
              end
              mq.push_back(e);
            end
            m_discard = 0;
          end
        end else if (!m_halted && lvl0 < DEPTH) begin
          if (m_pc[1:0] != 2'b00) begin
            e.fault = 1; e.cause = 4'd0; e.pc = m_pc; e.data = 0;
            mq.push_back(e);
            m_halted = 1;
          end else begin
            m_busy = 1;
            m_req_addr = m_pc;
          end
        end
      end
    end
  end

  // Compare process: mid-cycle, every cycle once the model is live.
  always @(negedge clk) begin : compare
    ent_t e;
    if (m_live) begin
      check("ma_rd_req", ma_rd_req, m_busy);
      check("ma_addr", ma_addr, m_busy ? m_req_addr : m_pc);
      check("ma_data_mask", ma_data_mask, 4'hF);
      check("queue_level", queue_level, mq.size());
      check("inst_valid", inst_valid, mq.size() != 0);
      if (mq.size() != 0) begin
        check("inst_pc", inst_pc, mq[0].pc);
        check("inst_fault", inst_fault, mq[0].fault);
        if (mq[0].fault) check("inst_fault_cause", inst_fault_cause, mq[0].cause);
        else             check("inst_data", inst_data, mq[0].data);
      end else begin
        check("inst_fault_idle", inst_fault, 0);
      end
      if (inst_valid && inst_ready && !redirect) begin
        e.fault = inst_fault; e.cause = inst_fault_cause; e.pc = inst_pc; e.data = inst_data;
        acc_log.push_back(e);
        acc_cyc.push_back(cyc_n);
      end
      if (ma_rd_req && !prev_rd) req_log.push_back(ma_addr);
      prev_rd = ma_rd_req;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic advance();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input bit rdy, input bit redir, input bit [31:0] rpc);
    ma_done = 0; ma_timeout = 0; ma_data_in = $urandom;
    if (rst || !ma_rd_req) begin
      resp_cnt = -1;
    end else begin
      if (resp_cnt < 0) resp_cnt = (lat_cfg < 0) ? int'($urandom_range(0, 3)) : lat_cfg;
      if (resp_cnt == 0) begin
        resp_cnt = -1;
        if ((to_en && ma_addr == to_addr) || (rand_to && $urandom_range(0, 19) == 0)) begin
          ma_timeout = 1;
          ma_done    = rand_to && ($urandom_range(0, 1) == 1);
        end else begin
          ma_done    = 1;
          ma_data_in = mem_word(ma_addr);
        end
      end else begin
        resp_cnt--;
      end
    end
    inst_ready = rdy; redirect = redir; redirect_pc = rpc;
  endtask

  task automatic run(input int n, input bit rdy);
    repeat (n) begin advance(); drive(rdy, 0, 0); end
  endtask

  task automatic do_reset();
    advance(); rst = 1; drive(0, 0, 0);
    advance(); drive(0, 0, 0);
    advance(); rst = 0; drive(0, 0, 0);
  endtask

  task automatic check_acc(input string name, input int idx, input bit fault,
                           input bit [3:0] cause, input bit [31:0] pc);
    check({name, "_present"}, acc_log.size() > idx, 1);
    if (acc_log.size() > idx) begin
      check({name, "_pc"}, acc_log[idx].pc, pc);
      check({name, "_fault"}, acc_log[idx].fault, fault);
      if (fault) check({name, "_cause"}, acc_log[idx].cause, cause);
      else       check({name, "_data"}, acc_log[idx].data, mem_word(pc));
    end
  endtask

  task automatic check_req(input string name, input int idx, input bit [31:0] addr);
    check({name, "_present"}, req_log.size() > idx, 1);
    if (req_log.size() > idx) check({name, "_addr"}, req_log[idx], addr);
  endtask

  initial begin : watchdog
    #2_000_000;
    n_bad++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin : stimulus
    int  a0, r0;
    bit  found;
    rst = 1; redirect = 0; redirect_pc = 0; inst_ready = 0;
    ma_done = 0; ma_timeout = 0; ma_data_in = 0;

    // Reset values
    do_reset();
    check("rst_rd_req", ma_rd_req, 0);
    check("rst_ma_addr", ma_addr, 32'h4000_0000);
    check("rst_level", queue_level, 0);
    check("rst_valid", inst_valid, 0);
    check("rst_fault", inst_fault, 0);

    // Zero-wait memory, always ready: one instruction every two cycles
    lat_cfg = 0;
    a0 = acc_log.size();
    run(12, 1);
    check_acc("seq0", a0,     0, 0, 32'h4000_0000);
    check_acc("seq1", a0 + 1, 0, 0, 32'h4000_0004);
    check_acc("seq2", a0 + 2, 0, 0, 32'h4000_0008);
    if (acc_cyc.size() > a0 + 1) check("seq_spacing", acc_cyc[a0 + 1] - acc_cyc[a0], 2);

    // Consumer stalled: exactly DEPTH requests, then the queue is full
    do_reset();
    r0 = req_log.size();
    run(20, 0);
    check("full_req_count", req_log.size() - r0, 4);
    check("full_level", queue_level, 4);
    check("full_rd_req", ma_rd_req, 0);

    // Access fault on the third fetch, then silence until redirect
    do_reset();
    to_en = 1; to_addr = 32'h4000_0008;
    r0 = req_log.size(); a0 = acc_log.size();
    run(15, 1);
    check_acc("tmo0", a0,     0, 0, 32'h4000_0000);
    check_acc("tmo1", a0 + 1, 0, 0, 32'h4000_0004);
    check_acc("tmo2", a0 + 2, 1, 1, 32'h4000_0008);
    check("tmo_req_count", req_log.size() - r0, 3);
    to_en = 0;

    // Redirect to a misaligned PC: fault entry, no request
    r0 = req_log.size(); a0 = acc_log.size();
    advance(); drive(1, 1, 32'h4000_0102);
    run(10, 1);
    check_acc("mis", a0, 1, 0, 32'h4000_0102);
    check("mis_req_count", req_log.size() - r0, 0);

    // Redirect while the request to 0x4000000C is outstanding
    do_reset();
    lat_cfg = 3;
    found = 0;
    for (int i = 0; i < 100 && !found; i++) begin
      advance();
      if (ma_rd_req && ma_addr == 32'h4000_000C) found = 1;
      else drive(1, 0, 0);
    end
    check("drain_found", found, 1);
    r0 = req_log.size(); a0 = acc_log.size();
    drive(1, found, 32'h8000_0000);
    run(20, 1);
    check_req("drain_old", r0, 32'h4000_000C);
    check_req("drain_new", r0 + 1, 32'h8000_0000);
    check_acc("drain_first", a0, 0, 0, 32'h8000_0000);

    // Redirect + pop + ma_done in the same cycle at level 2
    do_reset();
    lat_cfg = 0;
    found = 0;
    for (int i = 0; i < 100 && !found; i++) begin
      advance();
      if (ma_rd_req && queue_level == 2) found = 1;
      else drive(0, 0, 0);
    end
    check("rpd_found", found, 1);
    r0 = req_log.size(); a0 = acc_log.size();
    drive(1, found, 32'h4000_2000);
    advance();
    check("rpd_level", queue_level, 0);
    check("rpd_valid", inst_valid, 0);
    check("rpd_rd_req", ma_rd_req, 0);
    check("rpd_ma_addr", ma_addr, 32'h4000_2000);
    drive(1, 0, 0);
    run(10, 1);
    check_req("rpd_old", r0, 32'h4000_0008);
    check_req("rpd_new", r0 + 1, 32'h4000_2000);
    check_acc("rpd_first", a0, 0, 0, 32'h4000_2000);

    // Randomised traffic against the model
    do_reset();
    lat_cfg = -1; rand_to = 1;
    for (int i = 0; i < 3000; i++) begin
      bit        rd, rr;
      bit [31:0] pc;
      advance();
      rst = ($urandom_range(0, 499) == 0);
      rd  = ($urandom_range(0, 3) != 0);
      rr  = ($urandom_range(0, 39) == 0);
      case ($urandom_range(0, 7))
        0:       pc = 32'hFFFF_FFF0 | ($urandom_range(0, 3) << 2);   // wrap past 2^32
        1:       pc = 32'h4000_0000 | $urandom_range(0, 1023);      // possibly misaligned
        default: pc = 32'h4000_0000 | ($urandom_range(0, 1023) << 2);
      endcase
      drive(rd, rr, pc);
    end
    advance(); rst = 0; drive(1, 0, 0);
    run(20, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
